// File: rtl/gpu_cache_req_arbiter_pkg.sv
// gpu_cache_req_arbiter_pkg: shared FSM states, cache field defaults and index-width helper.
package gpu_cache_pkg;
  localparam int MIP_BITS_DEF = 2;
  localparam int PIXEL_WIDTH_DEF = 32;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;
  function automatic int client_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gpu_cache_req_arbiter_if.sv
// gpu_cache_req_arbiter_if: client request/response and cache port bundle; master is the arbiter side.
interface gpu_cache_req_arbiter_if
  import gpu_cache_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int MIP_BITS = MIP_BITS_DEF,
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
);
  logic [NUM_CLIENTS-1:0] cl_req_valid;
  logic [NUM_CLIENTS-1:0] cl_req_ready;
  logic [32*NUM_CLIENTS-1:0] cl_req_x;
  logic [32*NUM_CLIENTS-1:0] cl_req_y;
  logic [MIP_BITS*NUM_CLIENTS-1:0] cl_req_mip;
  logic [NUM_CLIENTS-1:0] cl_rsp_valid;
  logic [NUM_CLIENTS-1:0] cl_rsp_ready;
  logic [PIXEL_WIDTH-1:0] cl_rsp_pixel;
  logic cl_rsp_err;
  logic cache_req_valid;
  logic cache_req_ready;
  logic [31:0] cache_req_x;
  logic [31:0] cache_req_y;
  logic [MIP_BITS-1:0] cache_req_mip;
  logic [PIXEL_WIDTH-1:0] cache_pixel_out;
  logic cache_pixel_valid;
  modport master (
    input cl_req_valid, cl_req_x, cl_req_y, cl_req_mip, cl_rsp_ready,
    input cache_req_ready, cache_pixel_out, cache_pixel_valid,
    output cl_req_ready, cl_rsp_valid, cl_rsp_pixel, cl_rsp_err,
    output cache_req_valid, cache_req_x, cache_req_y, cache_req_mip
  );
  modport slave (
    output cl_req_valid, cl_req_x, cl_req_y, cl_req_mip, cl_rsp_ready,
    output cache_req_ready, cache_pixel_out, cache_pixel_valid,
    input cl_req_ready, cl_rsp_valid, cl_rsp_pixel, cl_rsp_err,
    input cache_req_valid, cache_req_x, cache_req_y, cache_req_mip
  );
endinterface

// File: rtl/gpu_cache_req_arbiter_rr.sv
// gpu_rr_arbiter: combinational round-robin pick of the first requester at or after rr_ptr.
module gpu_rr_arbiter
  import gpu_cache_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int CLIENT_BITS = client_bits(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [CLIENT_BITS-1:0] rr_ptr_i,
  output logic [NUM_CLIENTS-1:0] gnt_o,
  output logic [CLIENT_BITS-1:0] gnt_idx_o,
  output logic                   any_req_o
);
  logic [CLIENT_BITS-1:0] idx;
  // Scan farthest-first so the nearest requester after rr_ptr is written last.
  always_comb begin
    idx = '0;
    gnt_idx_o = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      idx = CLIENT_BITS'((int'(rr_ptr_i) + k) % NUM_CLIENTS);
      if (req_i[idx]) gnt_idx_o = idx;
    end
  end
  assign any_req_o = |req_i;
  assign gnt_o = any_req_o ? NUM_CLIENTS'(1) << gnt_idx_o : '0;
endmodule

// File: rtl/gpu_cache_req_arbiter.sv
// gpu_cache_req_arbiter: round-robin share of one cache request port with held fields, timeout and response return.
module gpu_cache_req_arbiter
  import gpu_cache_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int CLIENT_BITS = client_bits(NUM_CLIENTS),
  parameter int MIP_BITS = MIP_BITS_DEF,
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMO_BITS = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                   clk,
  input  logic                   rst,
  gpu_cache_req_arbiter_if.master bus,
  output logic                   busy,
  output logic [CLIENT_BITS-1:0] grant_id,
  output logic                   stray_rsp
);
  state_t                 state_q;
  logic [CLIENT_BITS-1:0] rr_ptr_q;
  logic [CLIENT_BITS-1:0] grant_q;
  logic [TMO_BITS-1:0]    tmo_q;
  logic [31:0]            x_q;
  logic [31:0]            y_q;
  logic [MIP_BITS-1:0]    mip_q;
  logic [PIXEL_WIDTH-1:0] pix_q;
  logic                   err_q;
  logic                   stray_q;
  logic [NUM_CLIENTS-1:0] gnt;
  logic [CLIENT_BITS-1:0] gnt_idx;
  logic                   any_req;
  logic [CLIENT_BITS-1:0] rr_next;

  gpu_rr_arbiter #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .CLIENT_BITS(CLIENT_BITS)
  ) u_rr (
    .req_i    (bus.cl_req_valid),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .any_req_o(any_req)
  );

  assign rr_next = (gnt_idx == CLIENT_BITS'(NUM_CLIENTS - 1)) ? '0 : gnt_idx + 1'b1;

  assign bus.cl_req_ready    = (state_q == S_IDLE) ? gnt : '0;
  assign bus.cl_rsp_valid    = (state_q == S_DELIVER) ? NUM_CLIENTS'(1) << grant_q : '0;
  assign bus.cl_rsp_pixel    = pix_q;
  assign bus.cl_rsp_err      = err_q;
  assign bus.cache_req_valid = (state_q == S_ISSUE);
  assign bus.cache_req_x     = x_q;
  assign bus.cache_req_y     = y_q;
  assign bus.cache_req_mip   = mip_q;
  assign busy                = (state_q != S_IDLE);
  assign grant_id            = grant_q;
  assign stray_rsp           = stray_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      tmo_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mip_q    <= '0;
      pix_q    <= '0;
      err_q    <= 1'b0;
      stray_q  <= 1'b0;
    end else begin
      if (bus.cache_pixel_valid && state_q != S_WAIT) stray_q <= 1'b1;
      case (state_q)
        S_IDLE: if (any_req) begin
          x_q      <= bus.cl_req_x[32*gnt_idx +: 32];
          y_q      <= bus.cl_req_y[32*gnt_idx +: 32];
          mip_q    <= bus.cl_req_mip[MIP_BITS*gnt_idx +: MIP_BITS];
          grant_q  <= gnt_idx;
          rr_ptr_q <= rr_next;
          state_q  <= S_ISSUE;
        end
        S_ISSUE: if (bus.cache_req_ready) begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        // A pixel arriving in the timeout cycle still wins over the error.
        S_WAIT: if (bus.cache_pixel_valid) begin
          pix_q   <= bus.cache_pixel_out;
          err_q   <= 1'b0;
          state_q <= S_DELIVER;
        end else if (tmo_q == TMO_BITS'(TIMEOUT_CYCLES - 1)) begin
          pix_q   <= '0;
          err_q   <= 1'b1;
          state_q <= S_DELIVER;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        S_DELIVER: if (bus.cl_rsp_ready[grant_q]) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_cache_req_arbiter.sv
// tb_gpu_cache_req_arbiter: directed vectors with hand-computed expectations for the cache request arbiter.
module tb_gpu_cache_req_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [1:0] grant_id;
  logic       stray_rsp;
  int         checks = 0;
  int         errors = 0;

  gpu_cache_req_arbiter_if #(.NUM_CLIENTS(4), .MIP_BITS(2), .PIXEL_WIDTH(32)) bus ();

  gpu_cache_req_arbiter #(
    .NUM_CLIENTS(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id),
    .stray_rsp(stray_rsp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cache_px(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
    return (x << 8) ^ y ^ {30'h0, m} ^ 32'h5A00_0000;
  endfunction

  task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
    bus.cl_req_x[32*i +: 32] = x;
    bus.cl_req_y[32*i +: 32] = y;
    bus.cl_req_mip[2*i +: 2] = m;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!bus.cache_req_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("issue_wait", bus.cache_req_valid, 1);
  endtask

  task automatic pulse(input logic [31:0] px);
    bus.cache_pixel_out = px;
    bus.cache_pixel_valid = 1'b1;
    @(negedge clk);
    bus.cache_pixel_valid = 1'b0;
  endtask

  task automatic release_rsp(input logic [3:0] r);
    bus.cl_rsp_ready = r;
    @(negedge clk);
    bus.cl_rsp_ready = '0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] px;
    bus.cl_req_valid = '0;
    bus.cl_req_x = '0;
    bus.cl_req_y = '0;
    bus.cl_req_mip = '0;
    bus.cl_rsp_ready = '0;
    bus.cache_req_ready = 1'b1;
    bus.cache_pixel_out = '0;
    bus.cache_pixel_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_stray", stray_rsp, 0);
    check("rst_cvalid", bus.cache_req_valid, 0);
    check("rst_rspv", bus.cl_rsp_valid, 0);
    check("rst_x", bus.cache_req_x, 0);

    // single request from client 1, pixel two cycles after accept
    set_req(1, 17, 9, 1);
    bus.cl_req_valid = 4'b0010;
    #1 check("t1_ready", bus.cl_req_ready, 4'b0010);
    @(negedge clk);
    bus.cl_req_valid = '0;
    check("t1_cvalid", bus.cache_req_valid, 1);
    check("t1_x", bus.cache_req_x, 17);
    check("t1_y", bus.cache_req_y, 9);
    check("t1_mip", bus.cache_req_mip, 1);
    check("t1_grant", grant_id, 1);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_wait_cvalid", bus.cache_req_valid, 0);
    check("t1_wait_x", bus.cache_req_x, 17);
    check("t1_wait_y", bus.cache_req_y, 9);
    check("t1_wait_mip", bus.cache_req_mip, 1);
    pulse(32'hDEADBEEF);
    check("t1_rspv", bus.cl_rsp_valid, 4'b0010);
    check("t1_pix", bus.cl_rsp_pixel, 32'hDEADBEEF);
    check("t1_err", bus.cl_rsp_err, 0);
    check("t1_dlv_x", bus.cache_req_x, 17);
    release_rsp(4'b0010);
    check("t1_idle", busy, 0);
    check("t1_rspv_off", bus.cl_rsp_valid, 0);

    // all four clients continuously valid: strict rotation from rr_ptr=0
    pulse_rst();
    for (int i = 0; i < 4; i++) set_req(i, 100 + i, 200 + i, 2'(i));
    bus.cl_req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      wait_issue();
      check($sformatf("rr%0d_grant", t), grant_id, t % 4);
      @(negedge clk);
      pulse(cache_px(bus.cache_req_x, bus.cache_req_y, bus.cache_req_mip));
      check($sformatf("rr%0d_rspv", t), bus.cl_rsp_valid, 4'b0001 << (t % 4));
      check($sformatf("rr%0d_pix", t), bus.cl_rsp_pixel,
            cache_px(32'(100 + t % 4), 32'(200 + t % 4), 2'(t % 4)));
      release_rsp(4'b1111);
    end
    bus.cl_req_valid = '0;

    // client 2 holds off the response for five cycles
    @(negedge clk);
    bus.cl_req_valid = 4'b0100;
    wait_issue();
    check("st_grant", grant_id, 2);
    bus.cl_req_valid = 4'b1011;
    @(negedge clk);
    pulse(32'hCAFE_0002);
    bus.cl_rsp_ready = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("st%0d_rspv", c), bus.cl_rsp_valid, 4'b0100);
      check($sformatf("st%0d_pix", c), bus.cl_rsp_pixel, 32'hCAFE_0002);
      check($sformatf("st%0d_reqrdy", c), bus.cl_req_ready, 0);
      @(negedge clk);
    end
    bus.cl_rsp_ready = 4'b0100;
    @(negedge clk);
    bus.cl_rsp_ready = '0;
    check("st_idle", busy, 0);
    check("st_rspv_off", bus.cl_rsp_valid, 0);
    check("st_next_rdy", bus.cl_req_ready, 4'b1000);
    bus.cl_req_valid = '0;

    // cache never answers: error response sixteen cycles after entering S_WAIT
    @(negedge clk);
    bus.cl_req_valid = 4'b0001;
    wait_issue();
    bus.cl_req_valid = '0;
    @(negedge clk);
    repeat (15) @(negedge clk);
    check("to_early_busy", busy, 1);
    check("to_early_rspv", bus.cl_rsp_valid, 0);
    @(negedge clk);
    check("to_rspv", bus.cl_rsp_valid, 4'b0001);
    check("to_err", bus.cl_rsp_err, 1);
    check("to_pix", bus.cl_rsp_pixel, 0);
    release_rsp(4'b0001);

    // pixel lands exactly in the timeout cycle: data wins
    bus.cl_req_valid = 4'b0010;
    wait_issue();
    bus.cl_req_valid = '0;
    @(negedge clk);
    repeat (15) @(negedge clk);
    check("tc_pending", bus.cl_rsp_valid, 0);
    pulse(32'h1234_5678);
    check("tc_rspv", bus.cl_rsp_valid, 4'b0010);
    check("tc_err", bus.cl_rsp_err, 0);
    check("tc_pix", bus.cl_rsp_pixel, 32'h1234_5678);
    release_rsp(4'b0010);

    // stray pixel while idle
    check("sy_before", stray_rsp, 0);
    pulse(32'h5555_AAAA);
    check("sy_set", stray_rsp, 1);
    check("sy_rspv", bus.cl_rsp_valid, 0);
    check("sy_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("sy_sticky", stray_rsp, 1);

    // reset during S_WAIT, then the abandoned pixel arrives late
    bus.cl_req_valid = 4'b0100;
    wait_issue();
    bus.cl_req_valid = '0;
    @(negedge clk);
    check("rw_busy_pre", busy, 1);
    pulse_rst();
    check("rw_busy", busy, 0);
    check("rw_grant", grant_id, 0);
    check("rw_stray", stray_rsp, 0);
    check("rw_rspv", bus.cl_rsp_valid, 0);
    check("rw_cvalid", bus.cache_req_valid, 0);
    check("rw_x", bus.cache_req_x, 0);
    check("rw_pix", bus.cl_rsp_pixel, 0);
    check("rw_err", bus.cl_rsp_err, 0);
    pulse(32'hBAD0_BAD0);
    check("rw_late_stray", stray_rsp, 1);
    check("rw_late_rspv", bus.cl_rsp_valid, 0);
    check("rw_late_busy", busy, 0);
    bus.cl_req_valid = 4'b1100;
    #1 check("rw_next_rdy", bus.cl_req_ready, 4'b0100);
    @(negedge clk);
    bus.cl_req_valid = '0;
    check("rw_next_grant", grant_id, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
